uart_cmd_capture: RTL and testbench

//  Parametrised command-frame front end sitting between UART_com RX/TX and the display/command logic.

---
 rtl/uart_cmd_capture_if.sv | 33 +++
 rtl/uart_cmd_capture.sv | 198 +++++++++++++++++++
 tb/tb_uart_cmd_capture.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_capture_if.sv
// rtl/uart_cmd_capture_if.sv - UART RX byte strobe and TX reply handshake bundle
//
// Signals:
//   byte_in        8  received byte from UART RX
//   byte_in_valid  1  one-cycle strobe, byte_in valid
//   tx_byte        8  reply byte towards UART TX
//   tx_valid       1  reply pending
//   tx_ready       1  TX accepts tx_byte when tx_valid & tx_ready
// master: the UART side (drives RX bytes and tx_ready)
// slave:  the command capture block
interface uart_cmd_capture_if;
    logic [7:0] byte_in;
    logic       byte_in_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output byte_in,
        output byte_in_valid,
        output tx_ready,
        input  tx_byte,
        input  tx_valid
    );

    modport slave (
        input  byte_in,
        input  byte_in_valid,
        input  tx_ready,
        output tx_byte,
        output tx_valid
    );
endinterface

// File: rtl/uart_cmd_capture.sv
// rtl/uart_cmd_capture.sv - UART command-frame capture with ACK/NAK reply and 7-seg digit scan
//
// Assembles {opcode,argument} frames MS byte first, enforces an inter-byte
// timeout, answers ACK (good frame) or NAK (timed-out frame) over the TX
// handshake, latches the last good frame and scans its nibbles onto digits.
//
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous active-low reset
//   uart          slave modport: byte_in/byte_in_valid in, tx_byte/tx_valid out, tx_ready in
//   cmd_valid     out  one-cycle pulse, new frame on opcode/command
//   opcode        out  last good opcode (8*OPCODE_BYTES)
//   command       out  last good argument (8*ARG_BYTES, 1 bit tied 0 when ARG_BYTES=0)
//   frame_error   out  one-cycle pulse on timeout discard
//   overrun       out  one-cycle pulse on byte dropped while replying
//   digit_sel     out  one-hot active-high digit enable
//   digit_nibble  out  nibble for the selected digit
module uart_cmd_capture #(
    parameter int         OPCODE_BYTES   = 1,
    parameter int         ARG_BYTES      = 4,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         NUM_DIGITS     = 8,
    parameter int         SCAN_DIV       = 20000
) (
    input  logic                                         clock,
    input  logic                                         reset,
    uart_cmd_capture_if.slave                            uart,
    output logic                                         cmd_valid,
    output logic [8*OPCODE_BYTES-1:0]                    opcode,
    output logic [((ARG_BYTES > 0) ? 8*ARG_BYTES : 1)-1:0] command,
    output logic                                         frame_error,
    output logic                                         overrun,
    output logic [NUM_DIGITS-1:0]                        digit_sel,
    output logic [3:0]                                   digit_nibble
);
    localparam int FRAME_BYTES = OPCODE_BYTES + ARG_BYTES;
    localparam int FW  = 8 * FRAME_BYTES;
    localparam int CW  = $clog2(FRAME_BYTES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic [FW-1:0] hold_q, hold_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          cmd_valid_d, frame_error_d, overrun_d;

    logic [FW-1:0] shifted;
    logic [CW-1:0] next_count;

    assign shifted    = (shreg_q << 8) | FW'(uart.byte_in);
    assign next_count = count_q + CW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= '0;
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            cmd_valid   <= cmd_valid_d;
            frame_error <= frame_error_d;
            overrun     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        hold_d        = hold_q;
        count_d       = count_q;
        timer_d       = timer_q;
        tx_valid_d    = tx_valid_q;
        tx_byte_d     = tx_byte_q;
        cmd_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (uart.byte_in_valid) begin
                    timer_d = '0;
                    if (FRAME_BYTES == 1) begin
                        hold_d      = FW'(uart.byte_in);
                        cmd_valid_d = 1'b1;
                        tx_byte_d   = ACK_BYTE;
                        tx_valid_d  = 1'b1;
                        count_d     = '0;
                        state_d     = SEND;
                    end else begin
                        shreg_d = FW'(uart.byte_in);
                        count_d = CW'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                // A byte on the same cycle the timer expires still counts as in time.
                if (uart.byte_in_valid) begin
                    timer_d = '0;
                    if (next_count == CW'(FRAME_BYTES)) begin
                        hold_d      = shifted;
                        cmd_valid_d = 1'b1;
                        tx_byte_d   = ACK_BYTE;
                        tx_valid_d  = 1'b1;
                        count_d     = '0;
                        state_d     = SEND;
                    end else begin
                        shreg_d = shifted;
                        count_d = next_count;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
                    frame_error_d = 1'b1;
                    tx_byte_d     = NAK_BYTE;
                    tx_valid_d    = 1'b1;
                    count_d       = '0;
                    timer_d       = '0;
                    state_d       = SEND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SEND: begin
                tx_valid_d = 1'b1;
                if (uart.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
                if (uart.byte_in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    assign uart.tx_valid = tx_valid_q;
    assign uart.tx_byte  = tx_byte_q;
    assign opcode        = hold_q[FW-1 -: 8*OPCODE_BYTES];

    generate
        if (ARG_BYTES > 0) begin : g_cmd
            assign command = hold_q[8*ARG_BYTES-1:0];
        end else begin : g_no_cmd
            assign command = 1'b0;
        end
    endgenerate

    // Digit scan: free-running, independent of the frame FSM. The nibble is
    // registered from the index digit_sel moves to, so both change together.
    logic [SW-1:0]  scan_cnt_q;
    logic [DIW-1:0] digit_idx_q;
    logic           scan_wrap;
    logic [DIW-1:0] idx_next;
    logic [DIW-1:0] idx_after_wrap;

    assign scan_wrap      = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign idx_after_wrap = (digit_idx_q == DIW'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + DIW'(1);
    assign idx_next       = scan_wrap ? idx_after_wrap : digit_idx_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            digit_sel    <= NUM_DIGITS'(1);
            digit_nibble <= '0;
        end else begin
            scan_cnt_q   <= scan_wrap ? '0 : scan_cnt_q + SW'(1);
            digit_idx_q  <= idx_next;
            digit_sel    <= NUM_DIGITS'(1) << idx_next;
            digit_nibble <= 4'(hold_q >> {idx_next, 2'b00});
        end
    end
endmodule

// File: tb/tb_uart_cmd_capture.sv
// tb/tb_uart_cmd_capture.sv - directed self-checking bench for uart_cmd_capture
module tb_uart_cmd_capture;
    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        frame_error;
    logic        overrun;
    logic [7:0]  digit_sel;
    logic [3:0]  digit_nibble;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] nib_exp [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

    uart_cmd_capture_if u_if ();

    uart_cmd_capture #(
        .OPCODE_BYTES   (1),
        .ARG_BYTES      (4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15),
        .NUM_DIGITS     (8),
        .SCAN_DIV       (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart         (u_if.slave),
        .cmd_valid    (cmd_valid),
        .opcode       (opcode),
        .command      (command),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .digit_sel    (digit_sel),
        .digit_nibble (digit_nibble)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.byte_in       = b;
        u_if.byte_in_valid = 1'b1;
        tick();
        u_if.byte_in_valid = 1'b0;
    endtask

    task automatic handshake();
        u_if.tx_ready = 1'b1;
        tick();
        u_if.tx_ready = 1'b0;
        check("tx_valid_after_handshake", 64'(u_if.tx_valid), 64'd0);
    endtask

    initial begin
        int guard;
        logic [7:0] esel;

        u_if.byte_in       = 8'h00;
        u_if.byte_in_valid = 1'b0;
        u_if.tx_ready      = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_opcode", 64'(opcode), 64'd0);
        check("rst_command", 64'(command), 64'd0);
        check("rst_tx_valid", 64'(u_if.tx_valid), 64'd0);
        check("rst_tx_byte", 64'(u_if.tx_byte), 64'd0);
        check("rst_frame_error", 64'(frame_error), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_digit_sel", 64'(digit_sel), 64'h01);
        check("rst_digit_nibble", 64'(digit_nibble), 64'd0);
        reset = 1'b1;
        tick();

        // Good frame, bytes 10 clk apart
        send_byte(8'hA5); repeat (9) tick();
        send_byte(8'h12); repeat (9) tick();
        send_byte(8'h34); repeat (9) tick();
        send_byte(8'h56); repeat (9) tick();
        check("f1_no_early_cmd", 64'(cmd_valid), 64'd0);
        send_byte(8'h78);
        check("f1_cmd_valid", 64'(cmd_valid), 64'd1);
        check("f1_opcode", 64'(opcode), 64'hA5);
        check("f1_command", 64'(command), 64'h12345678);
        check("f1_tx_valid", 64'(u_if.tx_valid), 64'd1);
        check("f1_tx_byte", 64'(u_if.tx_byte), 64'h06);
        repeat (3) tick();
        check("f1_cmd_pulse_end", 64'(cmd_valid), 64'd0);
        check("f1_tx_valid_held", 64'(u_if.tx_valid), 64'd1);
        check("f1_tx_byte_held", 64'(u_if.tx_byte), 64'h06);
        handshake();

        // Timeout discards partial frame
        send_byte(8'h11); repeat (9) tick();
        send_byte(8'h22);
        repeat (TIMEOUT) tick();
        check("to_not_yet", 64'(frame_error), 64'd0);
        check("to_no_tx_yet", 64'(u_if.tx_valid), 64'd0);
        tick();
        check("to_frame_error", 64'(frame_error), 64'd1);
        check("to_tx_valid", 64'(u_if.tx_valid), 64'd1);
        check("to_tx_byte", 64'(u_if.tx_byte), 64'h15);
        check("to_no_cmd", 64'(cmd_valid), 64'd0);
        check("to_opcode_kept", 64'(opcode), 64'hA5);
        check("to_command_kept", 64'(command), 64'h12345678);
        tick();
        check("to_pulse_end", 64'(frame_error), 64'd0);
        handshake();

        // Byte exactly on the timeout cycle is accepted
        send_byte(8'h11);
        repeat (TIMEOUT) tick();
        send_byte(8'h22);
        check("edge_no_error", 64'(frame_error), 64'd0);
        check("edge_no_tx", 64'(u_if.tx_valid), 64'd0);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        check("edge_cmd_valid", 64'(cmd_valid), 64'd1);
        check("edge_opcode", 64'(opcode), 64'h11);
        check("edge_command", 64'(command), 64'h22334455);
        check("edge_tx_byte", 64'(u_if.tx_byte), 64'h06);
        check("edge_frame_error", 64'(frame_error), 64'd0);
        handshake();

        // Overrun while the reply is stalled
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        check("ov_cmd_valid", 64'(cmd_valid), 64'd1);
        repeat (50) tick();
        check("ov_tx_valid_stall", 64'(u_if.tx_valid), 64'd1);
        check("ov_tx_byte_stall", 64'(u_if.tx_byte), 64'h06);
        send_byte(8'h99);
        check("ov_overrun", 64'(overrun), 64'd1);
        tick();
        check("ov_pulse_end", 64'(overrun), 64'd0);
        check("ov_opcode", 64'(opcode), 64'hAA);
        check("ov_command", 64'(command), 64'hBBCCDDEE);
        handshake();
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        check("ov_next_cmd_valid", 64'(cmd_valid), 64'd1);
        check("ov_next_opcode", 64'(opcode), 64'hA5);
        check("ov_next_command", 64'(command), 64'h12345678);
        handshake();
        tick();

        // Digit scan over hold = A512345678
        guard = 0;
        while (digit_sel !== 8'h01 && guard < 40) begin
            tick();
            guard++;
        end
        while (digit_sel === 8'h01 && guard < 40) begin
            tick();
            guard++;
        end
        check("scan_align", 64'(guard < 40), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            esel = 8'd1 << (k % 8);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan_sel_d%0d_c%0d", k % 8, c), 64'(digit_sel), 64'(esel));
                check($sformatf("scan_nib_d%0d_c%0d", k % 8, c), 64'(digit_nibble), 64'(nib_exp[k % 8]));
                tick();
            end
        end

        // Reset during COLLECT
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        reset = 1'b0;
        #2;
        check("mr_opcode", 64'(opcode), 64'd0);
        check("mr_command", 64'(command), 64'd0);
        check("mr_cmd_valid", 64'(cmd_valid), 64'd0);
        check("mr_tx_valid", 64'(u_if.tx_valid), 64'd0);
        check("mr_digit_sel", 64'(digit_sel), 64'h01);
        check("mr_digit_nibble", 64'(digit_nibble), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mr_tx_valid_after", 64'(u_if.tx_valid), 64'd0);
        send_byte(8'hC3);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        check("mr_no_early_cmd", 64'(cmd_valid), 64'd0);
        send_byte(8'hEF);
        check("mr_cmd_valid_new", 64'(cmd_valid), 64'd1);
        check("mr_opcode_new", 64'(opcode), 64'hC3);
        check("mr_command_new", 64'(command), 64'hDEADBEEF);
        check("mr_tx_byte_new", 64'(u_if.tx_byte), 64'h06);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
